// File: rtl/time_set_pkg.sv
// Shared types and constants for the time-entry controller and the times block.
package time_set_pkg;

   localparam int unsigned VAL_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT_HOUR,
      ST_EDIT_MIN,
      ST_EDIT_REM,
      ST_COMMIT_CLK,
      ST_COMMIT_REM
   } state_e;

   localparam logic [1:0] SET_RUN = 2'b00;
   localparam logic [1:0] SET_CLK = 2'b01;
   localparam logic [1:0] SET_REM = 2'b10;

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_HOUR = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;
   localparam logic [1:0] FIELD_REM  = 2'b11;

   localparam logic [VAL_W-1:0] HOUR_MAX = VAL_W'(23);
   localparam logic [VAL_W-1:0] MIN_MAX  = VAL_W'(59);
   localparam logic [VAL_W-1:0] REM_MIN  = VAL_W'(1);
   localparam logic [VAL_W-1:0] REM_RST  = VAL_W'(10);

   function automatic logic [VAL_W-1:0] clamp_max(input logic [VAL_W-1:0] v,
                                                  input logic [VAL_W-1:0] hi);
      return (v > hi) ? hi : v;
   endfunction

   // One modular step inside [lo, hi]; up=0 steps down.
   function automatic logic [VAL_W-1:0] step_wrap(input logic [VAL_W-1:0] v,
                                                  input logic [VAL_W-1:0] lo,
                                                  input logic [VAL_W-1:0] hi,
                                                  input logic             up);
      if (up) return (v >= hi) ? lo : v + VAL_W'(1);
      return (v <= lo) ? hi : v - VAL_W'(1);
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, debounce, rising-edge press pulse and optional auto-repeat.
module btn_conditioner #(
   parameter bit          REPEAT_EN  = 1'b0,
   parameter int unsigned REPEAT_DLY = 50,
   parameter int unsigned REPEAT_PER = 10
) (
   input  logic clk_100Hz,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);
   import time_set_pkg::*;

   // Repeat counter parks at REPEAT_DLY and reloads so the next hit is REPEAT_PER later
   // (assumes REPEAT_DLY >= REPEAT_PER).
   localparam int unsigned       CNT_W    = $clog2(REPEAT_DLY + 1);
   localparam logic [CNT_W-1:0]  DLY_C    = CNT_W'(REPEAT_DLY);
   localparam logic [CNT_W-1:0]  RELOAD_C = CNT_W'(REPEAT_DLY - REPEAT_PER + 1);

   logic             sync1_q, sync2_q;
   logic             deb_q, deb_d;
   logic             deb_dly_q;
   logic             press_q, press_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;

   always_ff @(posedge clk_100Hz or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         press_q   <= 1'b0;
         rep_cnt_q <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         press_q   <= press_d;
         rep_cnt_q <= rep_cnt_d;
      end
   end

   always_comb begin
      deb_d     = deb_q;
      rep_cnt_d = '0;
      press_d   = 1'b0;
      if (sync1_q == sync2_q) deb_d = sync2_q;
      if (deb_q) rep_cnt_d = (rep_cnt_q == DLY_C) ? RELOAD_C : rep_cnt_q + CNT_W'(1);
      press_d = deb_q & ~deb_dly_q;
      if (REPEAT_EN && deb_q && (rep_cnt_q == DLY_C)) press_d = 1'b1;
   end

   assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-entry controller: edits hour/minute/remind in a shadow copy and issues
// one-cycle commit strobes to the times block; also drives display field/blink.
module time_set_ctrl #(
   parameter int unsigned REPEAT_DLY = 50,
   parameter int unsigned REPEAT_PER = 10,
   parameter int unsigned TIMEOUT    = 1000,
   parameter int unsigned BLINK_HALF = 25
) (
   input  logic       clk_100Hz,
   input  logic       reset,
   input  logic       power_on,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_confirm,
   input  logic [5:0] hour_in,
   input  logic [5:0] minute_in,
   output logic [1:0] set_all_times,
   output logic [5:0] btn_time_set,
   output logic [5:0] btn_min_set,
   output logic [1:0] edit_field,
   output logic [5:0] edit_value,
   output logic       blink
);
   import time_set_pkg::*;

   localparam int unsigned      TO_W    = $clog2(TIMEOUT + 1);
   localparam int unsigned      BL_W    = $clog2(BLINK_HALF + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [BL_W-1:0]  BL_LAST = BL_W'(BLINK_HALF - 1);

   logic mode_p, up_p, down_p, conf_p;

   btn_conditioner #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_mode (
      .clk_100Hz(clk_100Hz), .reset(reset), .btn_raw(btn_mode), .press(mode_p));
   btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
      .clk_100Hz(clk_100Hz), .reset(reset), .btn_raw(btn_up), .press(up_p));
   btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_down (
      .clk_100Hz(clk_100Hz), .reset(reset), .btn_raw(btn_down), .press(down_p));
   btn_conditioner #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_conf (
      .clk_100Hz(clk_100Hz), .reset(reset), .btn_raw(btn_confirm), .press(conf_p));

   state_e           state_q, state_d;
   logic [VAL_W-1:0] sh_hour_q, sh_hour_d, sh_min_q, sh_min_d, sh_rem_q, sh_rem_d;
   logic [VAL_W-1:0] rem_q, rem_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [BL_W-1:0]  bl_cnt_q, bl_cnt_d;
   logic             blink_q, blink_d;
   logic [1:0]       set_q, set_d, field_q, field_d;
   logic [VAL_W-1:0] bt_q, bt_d, bm_q, bm_d, value_q, value_d;
   logic             editing, any_pulse, timed_out;

   assign editing   = (state_q == ST_EDIT_HOUR) || (state_q == ST_EDIT_MIN) || (state_q == ST_EDIT_REM);
   assign any_pulse = mode_p | up_p | down_p | conf_p;
   assign timed_out = (to_cnt_q == TO_LAST) && !any_pulse;

   always_ff @(posedge clk_100Hz or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sh_hour_q <= '0;
         sh_min_q  <= '0;
         sh_rem_q  <= REM_RST;
         rem_q     <= REM_RST;
         to_cnt_q  <= '0;
         bl_cnt_q  <= '0;
         blink_q   <= 1'b0;
         set_q     <= SET_RUN;
         field_q   <= FIELD_NONE;
         bt_q      <= '0;
         bm_q      <= '0;
         value_q   <= '0;
      end else begin
         state_q   <= state_d;
         sh_hour_q <= sh_hour_d;
         sh_min_q  <= sh_min_d;
         sh_rem_q  <= sh_rem_d;
         rem_q     <= rem_d;
         to_cnt_q  <= to_cnt_d;
         bl_cnt_q  <= bl_cnt_d;
         blink_q   <= blink_d;
         set_q     <= set_d;
         field_q   <= field_d;
         bt_q      <= bt_d;
         bm_q      <= bm_d;
         value_q   <= value_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sh_hour_d = sh_hour_q;
      sh_min_d  = sh_min_q;
      sh_rem_d  = sh_rem_q;
      rem_d     = rem_q;
      to_cnt_d  = (editing && !any_pulse) ? to_cnt_q + TO_W'(1) : '0;
      bl_cnt_d  = '0;
      blink_d   = 1'b0;
      set_d     = SET_RUN;
      field_d   = FIELD_NONE;
      bt_d      = bt_q;
      bm_d      = bm_q;
      value_d   = '0;

      case (state_q)
         ST_IDLE: begin
            if (mode_p && power_on) begin
               state_d   = ST_EDIT_HOUR;
               sh_hour_d = clamp_max(hour_in, HOUR_MAX);
               sh_min_d  = clamp_max(minute_in, MIN_MAX);
               sh_rem_d  = rem_q;
            end
         end
         ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_REM: begin
            // Priority: abort, confirm, mode, then a lone up/down step.
            if (!power_on || timed_out) begin
               state_d = ST_IDLE;
            end else if (conf_p) begin
               state_d = (state_q == ST_EDIT_REM) ? ST_COMMIT_REM : ST_COMMIT_CLK;
            end else if (mode_p) begin
               state_d = (state_q == ST_EDIT_HOUR) ? ST_EDIT_MIN :
                         (state_q == ST_EDIT_MIN)  ? ST_EDIT_REM : ST_EDIT_HOUR;
            end else if (up_p ^ down_p) begin
               if (state_q == ST_EDIT_HOUR)     sh_hour_d = step_wrap(sh_hour_q, VAL_W'(0), HOUR_MAX, up_p);
               else if (state_q == ST_EDIT_MIN) sh_min_d  = step_wrap(sh_min_q, VAL_W'(0), MIN_MAX, up_p);
               else                             sh_rem_d  = step_wrap(sh_rem_q, REM_MIN, HOUR_MAX, up_p);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      case (state_d)
         ST_EDIT_HOUR: begin field_d = FIELD_HOUR; value_d = sh_hour_d; end
         ST_EDIT_MIN:  begin field_d = FIELD_MIN;  value_d = sh_min_d;  end
         ST_EDIT_REM:  begin field_d = FIELD_REM;  value_d = sh_rem_d;  end
         ST_COMMIT_CLK: begin
            set_d = SET_CLK;
            bt_d  = sh_hour_d;
            bm_d  = sh_min_d;
         end
         ST_COMMIT_REM: begin
            set_d = SET_REM;
            bt_d  = sh_rem_d;
            bm_d  = '0;
            rem_d = sh_rem_d;
         end
         default: ;
      endcase

      if (field_d != FIELD_NONE) begin
         if (state_d != state_q) begin
            bl_cnt_d = '0;
            blink_d  = 1'b0;
         end else if (bl_cnt_q == BL_LAST) begin
            bl_cnt_d = '0;
            blink_d  = ~blink_q;
         end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
            blink_d  = blink_q;
         end
      end
   end

   assign set_all_times = set_q;
   assign btn_time_set  = bt_q;
   assign btn_min_set   = bm_q;
   assign edit_field    = field_q;
   assign edit_value    = value_q;
   assign blink         = blink_q;

endmodule
